// File: rtl/local_port_rx_credit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : local_port_rx_credit_buffer
// Brief    : Device-side receiver for the router's local output port. Buffers
//            flits per VC, presents one flit at a time over valid/ready with
//            RT-priority / common round-robin selection and hold-until-accept
//            locking, and returns one link credit per consumed flit.
// Config   : LOCAL_RX_CREDIT_INIT_EN - when defined, reset enters INIT and
//            the block issues VC_DEPTH credits per VC before running.
// Revision : 1.0 - initial release
// ============================================================================
module local_port_rx_credit_buffer #(
    parameter int VC_NUM     = 2,
    parameter int VC_DEPTH   = 2,
    parameter int FLIT_W     = 64,
    parameter int QOS_VC_NUM = 1,
    localparam int VC_ID_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flit_v_i,
    input  logic [VC_ID_W-1:0] flit_vc_id_i,
    input  logic [FLIT_W-1:0]  flit_i,
    output logic               dev_flit_v_o,
    output logic [FLIT_W-1:0]  dev_flit_o,
    output logic [VC_ID_W-1:0] dev_vc_id_o,
    input  logic               dev_flit_rdy_i,
    output logic               tx_lcrd_v_o,
    output logic [VC_ID_W-1:0] tx_lcrd_id_o,
    output logic               init_done_o,
    output logic               err_overflow_o
);

    localparam int CNT_W = $clog2(VC_DEPTH + 1);
    localparam int PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;

    localparam logic [CNT_W-1:0]   c_depth     = CNT_W'(VC_DEPTH);
    localparam logic [PTR_W-1:0]   c_last_slot = PTR_W'(VC_DEPTH - 1);
    localparam logic [VC_ID_W-1:0] c_last_vc   = VC_ID_W'(VC_NUM - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Per-VC storage and bookkeeping
    logic [FLIT_W-1:0]  r_mem  [VC_NUM][VC_DEPTH];
    logic [PTR_W-1:0]   r_wptr [VC_NUM];
    logic [PTR_W-1:0]   r_rptr [VC_NUM];
    logic [CNT_W-1:0]   r_cnt  [VC_NUM];

    logic [VC_NUM-1:0]  w_nonempty;
    logic [VC_NUM-1:0]  w_full;
    logic [VC_NUM-1:0]  w_tgt;
    logic [VC_NUM-1:0]  w_enq;
    logic [VC_NUM-1:0]  w_deq;

    // Control state
    state_t             r_state;
    logic               r_lock;
    logic               r_lock_common;
    logic [VC_ID_W-1:0] r_lock_vc;
    logic [VC_ID_W-1:0] r_rr_ptr;
    logic               r_crd_v;
    logic [VC_ID_W-1:0] r_crd_id;
    logic               r_err;
`ifdef LOCAL_RX_CREDIT_INIT_EN
    logic [VC_ID_W-1:0] r_init_vc;
    logic [PTR_W-1:0]   r_init_slot;
    logic               r_init_fin;
`endif

    // Selection
    logic               w_run;
    logic               w_rt_hit;
    logic [VC_ID_W-1:0] w_rt_vc;
    logic               w_rr_hit;
    logic [VC_ID_W-1:0] w_rr_vc;
    logic               w_sel_valid;
    logic               w_sel_common;
    logic [VC_ID_W-1:0] w_sel_vc;
    logic               w_hs;
    logic               w_ovf;
    int                 w_scan;

    assign w_run = (r_state == ST_RUN);

    for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
        assign w_nonempty[g] = (r_cnt[g] != '0);
        assign w_full[g]     = (r_cnt[g] == c_depth);
        assign w_tgt[g]      = (flit_vc_id_i == VC_ID_W'(g));
        assign w_deq[g]      = w_hs && (w_sel_vc == VC_ID_W'(g));
        // A full VC may still accept when it is popped in the same cycle.
        assign w_enq[g]      = w_run && flit_v_i && w_tgt[g] && (!w_full[g] || w_deq[g]);
    end

    // Arbitration: lowest non-empty RT VC first, else round-robin over common VCs
    always_comb begin
        w_rt_hit = 1'b0;
        w_rt_vc  = '0;
        w_rr_hit = 1'b0;
        w_rr_vc  = '0;
        w_scan   = 0;
        for (int v = QOS_VC_NUM - 1; v >= 0; v--) begin
            if (w_nonempty[v]) begin
                w_rt_hit = 1'b1;
                w_rt_vc  = VC_ID_W'(v);
            end
        end
        // Scan offsets downward so the candidate closest to the pointer wins.
        for (int off = VC_NUM - 1; off >= 0; off--) begin
            w_scan = int'(r_rr_ptr) + off;
            if (w_scan >= VC_NUM) begin
                w_scan = w_scan - VC_NUM;
            end
            if ((w_scan >= QOS_VC_NUM) && w_nonempty[w_scan[VC_ID_W-1:0]]) begin
                w_rr_hit = 1'b1;
                w_rr_vc  = VC_ID_W'(w_scan);
            end
        end
    end

    // A held (locked) VC overrides arbitration until it is accepted.
    assign w_sel_valid  = r_lock ? 1'b1 : (w_rt_hit | w_rr_hit);
    assign w_sel_vc     = r_lock ? r_lock_vc : (w_rt_hit ? w_rt_vc : w_rr_vc);
    assign w_sel_common = r_lock ? r_lock_common : !w_rt_hit;

    assign dev_flit_v_o = w_run && w_sel_valid;
    assign dev_vc_id_o  = w_sel_vc;
    assign dev_flit_o   = r_mem[w_sel_vc][r_rptr[w_sel_vc]];
    assign w_hs         = dev_flit_v_o && dev_flit_rdy_i;

    // Flits outside RUN, or to a full VC that is not draining, are dropped as errors.
    assign w_ovf = flit_v_i && (!w_run || |(w_tgt & w_full & ~w_deq));

    assign tx_lcrd_v_o    = r_crd_v;
    assign tx_lcrd_id_o   = r_crd_id;
    assign err_overflow_o = r_err;
    assign init_done_o    = w_run;

    // FIFO pointers and occupancy per VC
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                r_wptr[v] <= '0;
                r_rptr[v] <= '0;
                r_cnt[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_enq[v]) begin
                    r_wptr[v] <= (r_wptr[v] == c_last_slot) ? '0 : r_wptr[v] + PTR_W'(1);
                end
                if (w_deq[v]) begin
                    r_rptr[v] <= (r_rptr[v] == c_last_slot) ? '0 : r_rptr[v] + PTR_W'(1);
                end
                if (w_enq[v] && !w_deq[v]) begin
                    r_cnt[v] <= r_cnt[v] + CNT_W'(1);
                end else if (!w_enq[v] && w_deq[v]) begin
                    r_cnt[v] <= r_cnt[v] - CNT_W'(1);
                end
            end
        end
    end

    // Flit payload storage (no reset needed; occupancy guards visibility)
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (w_enq[v]) begin
                r_mem[v][r_wptr[v]] <= flit_i;
            end
        end
    end

    // Control FSM: credit init sequence, lock, RR pointer, credit return, sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef LOCAL_RX_CREDIT_INIT_EN
            r_state     <= ST_INIT;
            r_init_vc   <= '0;
            r_init_slot <= '0;
            r_init_fin  <= 1'b0;
`else
            r_state     <= ST_RUN;
`endif
            r_lock        <= 1'b0;
            r_lock_vc     <= '0;
            r_lock_common <= 1'b0;
            r_rr_ptr      <= '0;
            r_crd_v       <= 1'b0;
            r_crd_id      <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_ovf) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_INIT: begin
`ifdef LOCAL_RX_CREDIT_INIT_EN
                    if (r_init_fin) begin
                        r_crd_v <= 1'b0;
                        r_state <= ST_RUN;
                    end else begin
                        r_crd_v  <= 1'b1;
                        r_crd_id <= r_init_vc;
                        if (r_init_slot == c_last_slot) begin
                            r_init_slot <= '0;
                            if (r_init_vc == c_last_vc) begin
                                r_init_fin <= 1'b1;
                            end else begin
                                r_init_vc <= r_init_vc + VC_ID_W'(1);
                            end
                        end else begin
                            r_init_slot <= r_init_slot + PTR_W'(1);
                        end
                    end
`else
                    r_state <= ST_RUN;
`endif
                end
                ST_RUN: begin
                    r_crd_v <= w_hs;
                    if (w_hs) begin
                        r_crd_id <= w_sel_vc;
                        r_lock   <= 1'b0;
                        if (w_sel_common) begin
                            r_rr_ptr <= (w_sel_vc == c_last_vc) ? '0 : w_sel_vc + VC_ID_W'(1);
                        end
                    end else if (dev_flit_v_o) begin
                        r_lock        <= 1'b1;
                        r_lock_vc     <= w_sel_vc;
                        r_lock_common <= w_sel_common;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_local_port_rx_credit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_local_port_rx_credit_buffer
// Brief    : Self-checking bench for local_port_rx_credit_buffer using a
//            queue-based reference model, directed scenarios and
//            credit-respecting random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_local_port_rx_credit_buffer;

    localparam int VC_NUM     = 3;
    localparam int VC_DEPTH   = 2;
    localparam int FLIT_W     = 32;
    localparam int QOS_VC_NUM = 1;
    localparam int VC_ID_W    = 2;
    localparam int TOTAL_CRD  = VC_NUM * VC_DEPTH;
`ifdef LOCAL_RX_CREDIT_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               flit_v_i;
    logic [VC_ID_W-1:0] flit_vc_id_i;
    logic [FLIT_W-1:0]  flit_i;
    logic               dev_flit_v_o;
    logic [FLIT_W-1:0]  dev_flit_o;
    logic [VC_ID_W-1:0] dev_vc_id_o;
    logic               dev_flit_rdy_i;
    logic               tx_lcrd_v_o;
    logic [VC_ID_W-1:0] tx_lcrd_id_o;
    logic               init_done_o;
    logic               err_overflow_o;

    local_port_rx_credit_buffer #(
        .VC_NUM     (VC_NUM),
        .VC_DEPTH   (VC_DEPTH),
        .FLIT_W     (FLIT_W),
        .QOS_VC_NUM (QOS_VC_NUM)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .flit_v_i       (flit_v_i),
        .flit_vc_id_i   (flit_vc_id_i),
        .flit_i         (flit_i),
        .dev_flit_v_o   (dev_flit_v_o),
        .dev_flit_o     (dev_flit_o),
        .dev_vc_id_o    (dev_vc_id_o),
        .dev_flit_rdy_i (dev_flit_rdy_i),
        .tx_lcrd_v_o    (tx_lcrd_v_o),
        .tx_lcrd_id_o   (tx_lcrd_id_o),
        .init_done_o    (init_done_o),
        .err_overflow_o (err_overflow_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [FLIT_W-1:0] mq [VC_NUM][$];
    bit  m_known   = 1'b0;
    bit  m_run;
    bit  m_lock;
    int  m_lock_vc;
    int  m_rr;
    bit  m_err;
    bit  m_crd_v;
    int  m_crd_id;
    int  m_init_k;
    int  rtr_cred [VC_NUM];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Which VC the device should see: held VC, else first RT VC, else RR among common VCs.
    function automatic int pick();
        if (m_lock) return m_lock_vc;
        for (int v = 0; v < QOS_VC_NUM; v++) begin
            if (mq[v].size() > 0) return v;
        end
        for (int k = 0; k < VC_NUM; k++) begin
            int v;
            v = (m_rr + k) % VC_NUM;
            if (v >= QOS_VC_NUM && mq[v].size() > 0) return v;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) begin
            mq[v].delete();
            rtr_cred[v] = INIT_EN ? 0 : VC_DEPTH;
        end
        m_known   = 1'b1;
        m_run     = !INIT_EN;
        m_lock    = 1'b0;
        m_lock_vc = 0;
        m_rr      = 0;
        m_err     = 1'b0;
        m_crd_v   = 1'b0;
        m_crd_id  = 0;
        m_init_k  = 0;
    endtask

    // One clock cycle: drive inputs, compare at negedge, advance model, step past posedge.
    task automatic tick(input logic r, input logic fv, input int vc,
                        input logic [FLIT_W-1:0] d, input logic rdy);
        int sel;
        bit hs;
        rst            = r;
        flit_v_i       = fv;
        flit_vc_id_i   = VC_ID_W'(vc);
        flit_i         = d;
        dev_flit_rdy_i = rdy;
        @(negedge clk);
        sel = m_run ? pick() : -1;
        if (m_known) begin
            chk("dev_v", dev_flit_v_o, sel >= 0);
            if (sel >= 0) begin
                chk("dev_id", dev_vc_id_o, sel);
                chk("dev_data", dev_flit_o, mq[sel][0]);
            end
            chk("crd_v", tx_lcrd_v_o, m_crd_v);
            chk("crd_id", tx_lcrd_id_o, m_crd_id);
            chk("err", err_overflow_o, m_err);
            chk("init_done", init_done_o, m_run);
        end
        if (tx_lcrd_v_o === 1'b1 && int'(tx_lcrd_id_o) < VC_NUM) rtr_cred[tx_lcrd_id_o]++;
        if (r) begin
            model_reset();
        end else if (!m_run) begin
            if (fv) m_err = 1'b1;
            if (m_init_k < TOTAL_CRD) begin
                m_crd_v  = 1'b1;
                m_crd_id = m_init_k / VC_DEPTH;
            end else begin
                m_crd_v = 1'b0;
                m_run   = 1'b1;
            end
            m_init_k++;
        end else begin
            hs      = (sel >= 0) && rdy;
            m_crd_v = hs;
            if (hs) begin
                m_crd_id = sel;
                void'(mq[sel].pop_front());
                if (sel >= QOS_VC_NUM) m_rr = (sel + 1) % VC_NUM;
                m_lock = 1'b0;
            end else if (sel >= 0) begin
                m_lock    = 1'b1;
                m_lock_vc = sel;
            end
            if (fv) begin
                if (mq[vc].size() < VC_DEPTH) mq[vc].push_back(d);
                else m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, '0, rdy);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 0, '0, 1'b0);
        tick(1'b1, 1'b0, 0, '0, 1'b0);
        idle(10, 1'b1);
    endtask

    initial begin
        rst = 1'b1; flit_v_i = 1'b0; flit_vc_id_i = '0; flit_i = '0; dev_flit_rdy_i = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single flit to VC2, presented next cycle, credit the cycle after
        tick(1'b0, 1'b1, 2, 32'hA5, 1'b1);
        idle(3, 1'b1);

        // Load VC0, VC1, VC2, then drain; refill VC1, VC2 and drain again
        tick(1'b0, 1'b1, 0, 32'h10, 1'b0);
        tick(1'b0, 1'b1, 1, 32'h11, 1'b0);
        tick(1'b0, 1'b1, 2, 32'h12, 1'b0);
        idle(4, 1'b1);
        tick(1'b0, 1'b1, 1, 32'h21, 1'b0);
        tick(1'b0, 1'b1, 2, 32'h22, 1'b0);
        idle(3, 1'b1);

        // VC1 held with rdy low while an RT flit arrives
        tick(1'b0, 1'b1, 1, 32'h31, 1'b0);
        tick(1'b0, 1'b0, 0, '0, 1'b0);
        tick(1'b0, 1'b1, 0, 32'h30, 1'b0);
        tick(1'b0, 1'b0, 0, '0, 1'b0);
        idle(3, 1'b1);

        // Overflow: third flit to a full VC is dropped and the error sticks
        tick(1'b0, 1'b1, 1, 32'h51, 1'b0);
        tick(1'b0, 1'b1, 1, 32'h52, 1'b0);
        tick(1'b0, 1'b1, 1, 32'h53, 1'b0);
        idle(1, 1'b0);
        idle(4, 1'b1);
        do_reset();

        // Full VC with simultaneous enqueue/dequeue, then reset with a credit pending
        tick(1'b0, 1'b1, 1, 32'h61, 1'b0);
        tick(1'b0, 1'b1, 1, 32'h62, 1'b0);
        tick(1'b0, 1'b1, 1, 32'h63, 1'b1);
        tick(1'b1, 1'b0, 0, '0, 1'b1);
        idle(10, 1'b1);

        // Random traffic from a credit-respecting router
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int   vc;
            logic fv;
            logic rr;
            vc = int'($urandom_range(VC_NUM - 1, 0));
            fv = ($urandom_range(99, 0) < 60) && (rtr_cred[vc] > 0);
            if (fv) rtr_cred[vc]--;
            rr = ($urandom_range(999, 0) < 3);
            tick(rr, fv, vc, $urandom, $urandom_range(99, 0) < 65);
        end
        idle(8, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
